// File: rtl/shift_reg_univ.sv
// Universal shift register: shift/rotate/load/clear with a per-frame shift counter,
// a one-cycle frame-complete pulse and a combinational pattern match.
module shift_reg_univ #(
   parameter int unsigned          WIDTH   = 8,
   parameter logic [WIDTH-1:0]     PATTERN = WIDTH'(8'hB1),
   parameter int unsigned          CNT_W   = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             data,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] q,
   output logic             q_ser,
   output logic [CNT_W-1:0] shift_cnt,
   output logic             frame_done,
   output logic             match
);

   typedef enum logic [2:0] {
      ModeHold = 3'b000,
      ModeShr  = 3'b001,
      ModeShl  = 3'b010,
      ModeRor  = 3'b011,
      ModeRol  = 3'b100,
      ModeLoad = 3'b101,
      ModeClr  = 3'b110,
      ModeRsvd = 3'b111
   } mode_e;

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] q_d;
   logic             q_ser_d;
   logic [CNT_W-1:0] cnt_d;
   logic             done_d;
   logic             is_shift;

   always_comb begin
      q_d      = q;
      q_ser_d  = q_ser;
      is_shift = 1'b0;
      cnt_d    = shift_cnt;
      done_d   = 1'b0;
      unique case (mode_e'(mode))
         ModeShr: begin
            q_d      = {data, q[WIDTH-1:1]};
            q_ser_d  = q[0];
            is_shift = 1'b1;
         end
         ModeShl: begin
            q_d      = {q[WIDTH-2:0], data};
            q_ser_d  = q[WIDTH-1];
            is_shift = 1'b1;
         end
         ModeRor: begin
            q_d      = {q[0], q[WIDTH-1:1]};
            q_ser_d  = q[0];
            is_shift = 1'b1;
         end
         ModeRol: begin
            q_d      = {q[WIDTH-2:0], q[WIDTH-1]};
            q_ser_d  = q[WIDTH-1];
            is_shift = 1'b1;
         end
         ModeLoad: begin
            q_d     = load_data;
            q_ser_d = 1'b0;
            cnt_d   = '0;
         end
         ModeClr: begin
            q_d     = '0;
            q_ser_d = 1'b0;
            cnt_d   = '0;
         end
         ModeHold, ModeRsvd: ;
         default: ;
      endcase
      // Wrap closes the frame; the next shift starts the following frame at 1.
      if (is_shift) begin
         if (shift_cnt == CntLast) begin
            cnt_d  = '0;
            done_d = 1'b1;
         end else begin
            cnt_d = shift_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q          <= '0;
         q_ser      <= 1'b0;
         shift_cnt  <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (en) begin
            q          <= q_d;
            q_ser      <= q_ser_d;
            shift_cnt  <= cnt_d;
            frame_done <= done_d;
         end
      end
   end

   assign match = (q == PATTERN);

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed self-checking bench for shift_reg_univ (WIDTH=8, PATTERN=8'hB1).
module tb_shift_reg_univ;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic [2:0] mode;
   logic       data;
   logic [7:0] load_data;
   logic [7:0] q;
   logic       q_ser;
   logic [3:0] shift_cnt;
   logic       frame_done;
   logic       match;

   int checks   = 0;
   int failures = 0;

   localparam logic [2:0] HOLD = 3'b000, SHR = 3'b001, SHL = 3'b010, ROR = 3'b011,
                          ROL = 3'b100, LOAD = 3'b101, CLR = 3'b110, RSVD = 3'b111;

   shift_reg_univ #(.WIDTH(8), .PATTERN(8'hB1)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .mode       (mode),
      .data       (data),
      .load_data  (load_data),
      .q          (q),
      .q_ser      (q_ser),
      .shift_cnt  (shift_cnt),
      .frame_done (frame_done),
      .match      (match)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one operation across a rising edge, then sample 1 time unit later.
   task automatic step(input logic [2:0] m, input logic d, input logic [7:0] ld);
      mode      = m;
      data      = d;
      load_data = ld;
      @(posedge clk);
      #1;
   endtask

   logic [7:0] bits3;

   initial begin
      reset = 1'b0; en = 1'b1; mode = HOLD; data = 1'b0; load_data = 8'h00;
      #12;
      chk("rst_q", 32'(q), 32'h00);
      chk("rst_qser", 32'(q_ser), 32'h0);
      chk("rst_cnt", 32'(shift_cnt), 32'h0);
      chk("rst_done", 32'(frame_done), 32'h0);
      chk("rst_match", 32'(match), 32'h0);
      @(negedge clk);
      reset = 1'b1;

      // 1: async reset mid-frame
      step(LOAD, 1'b0, 8'h5A);
      chk("t1_load", 32'(q), 32'h5A);
      step(SHR, 1'b0, 8'hFF);
      chk("t1_shr1", 32'(q), 32'h2D);
      step(SHR, 1'b0, 8'hFF);
      chk("t1_shr2_qser", 32'(q_ser), 32'h1);
      step(SHR, 1'b0, 8'hFF);
      chk("t1_shr3", 32'(q), 32'h0B);
      chk("t1_cnt3", 32'(shift_cnt), 32'h3);
      #1 reset = 1'b0;
      #1;
      chk("t1_async_q", 32'(q), 32'h00);
      chk("t1_async_qser", 32'(q_ser), 32'h0);
      chk("t1_async_cnt", 32'(shift_cnt), 32'h0);
      #1 reset = 1'b1;
      step(SHR, 1'b1, 8'h00);
      chk("t1_after_q", 32'(q), 32'h80);
      chk("t1_after_cnt", 32'(shift_cnt), 32'h1);

      // 2: SHR then SHL with serial out
      step(LOAD, 1'b1, 8'h81);
      chk("t2_load_cnt", 32'(shift_cnt), 32'h0);
      chk("t2_load_qser", 32'(q_ser), 32'h0);
      step(SHR, 1'b0, 8'h00);
      chk("t2_shr_q", 32'(q), 32'h40);
      chk("t2_shr_qser", 32'(q_ser), 32'h1);
      chk("t2_shr_cnt", 32'(shift_cnt), 32'h1);
      step(SHL, 1'b1, 8'h00);
      chk("t2_shl_q", 32'(q), 32'h81);
      chk("t2_shl_qser", 32'(q_ser), 32'h0);
      chk("t2_shl_cnt", 32'(shift_cnt), 32'h2);

      // 3: shift in the pattern, frame wrap, back-to-back frame
      step(CLR, 1'b1, 8'hFF);
      chk("t3_clr_q", 32'(q), 32'h00);
      chk("t3_clr_cnt", 32'(shift_cnt), 32'h0);
      bits3 = 8'b1011_0001;
      for (int i = 7; i >= 0; i--) begin
         step(SHL, bits3[i], 8'h00);
         if (i == 1) begin
            chk("t3_cnt7", 32'(shift_cnt), 32'h7);
            chk("t3_nodone7", 32'(frame_done), 32'h0);
            chk("t3_nomatch7", 32'(match), 32'h0);
         end
      end
      chk("t3_q", 32'(q), 32'hB1);
      chk("t3_match", 32'(match), 32'h1);
      chk("t3_done", 32'(frame_done), 32'h1);
      chk("t3_cnt_wrap", 32'(shift_cnt), 32'h0);
      step(SHL, 1'b0, 8'h00);
      chk("t3_9_q", 32'(q), 32'h62);
      chk("t3_9_match", 32'(match), 32'h0);
      chk("t3_9_done", 32'(frame_done), 32'h0);
      chk("t3_9_cnt", 32'(shift_cnt), 32'h1);

      // 4: rotate left a full frame
      step(LOAD, 1'b0, 8'h81);
      step(ROL, 1'b0, 8'h00);
      chk("t4_rol1_q", 32'(q), 32'h03);
      chk("t4_rol1_qser", 32'(q_ser), 32'h1);
      for (int i = 0; i < 7; i++) begin
         step(ROL, 1'b1, 8'hFF);
         chk("t4_rol_done", 32'(frame_done), (i == 6) ? 32'h1 : 32'h0);
      end
      chk("t4_rol8_q", 32'(q), 32'h81);
      chk("t4_rol8_cnt", 32'(shift_cnt), 32'h0);
      step(ROR, 1'b0, 8'h00);
      chk("t4_ror_q", 32'(q), 32'hC0);
      chk("t4_ror_qser", 32'(q_ser), 32'h1);
      chk("t4_ror_done", 32'(frame_done), 32'h0);

      // 5: enable low freezes state
      step(LOAD, 1'b0, 8'hF0);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(SHR, 1'b1, 8'h00);
         chk("t5_frz_q", 32'(q), 32'hF0);
         chk("t5_frz_cnt", 32'(shift_cnt), 32'h0);
         chk("t5_frz_done", 32'(frame_done), 32'h0);
      end
      en = 1'b1;
      step(SHR, 1'b0, 8'h00);
      chk("t5_shr_q", 32'(q), 32'h78);
      chk("t5_shr_cnt", 32'(shift_cnt), 32'h1);

      // 6: LOAD abandons a frame; reserved mode holds
      for (int i = 0; i < 3; i++) step(SHL, 1'b1, 8'h00);
      chk("t6_pre_cnt", 32'(shift_cnt), 32'h4);
      step(LOAD, 1'b1, 8'h00);
      chk("t6_load_cnt", 32'(shift_cnt), 32'h0);
      chk("t6_load_done", 32'(frame_done), 32'h0);
      for (int i = 0; i < 4; i++) begin
         step(SHL, 1'b1, 8'h00);
         chk("t6_nodone_a", 32'(frame_done), 32'h0);
      end
      for (int i = 0; i < 2; i++) begin
         step(RSVD, 1'b0, 8'hAA);
         chk("t6_rsvd_q", 32'(q), 32'h0F);
         chk("t6_rsvd_cnt", 32'(shift_cnt), 32'h4);
         chk("t6_rsvd_done", 32'(frame_done), 32'h0);
      end
      step(HOLD, 1'b0, 8'h55);
      chk("t6_hold_q", 32'(q), 32'h0F);
      for (int i = 0; i < 3; i++) begin
         step(SHL, 1'b1, 8'h00);
         chk("t6_nodone_b", 32'(frame_done), 32'h0);
      end
      chk("t6_cnt7", 32'(shift_cnt), 32'h7);
      chk("t6_q7", 32'(q), 32'h7F);
      step(SHL, 1'b1, 8'h00);
      chk("t6_done", 32'(frame_done), 32'h1);
      chk("t6_cnt_wrap", 32'(shift_cnt), 32'h0);
      step(HOLD, 1'b0, 8'h00);
      chk("t6_done_pulse", 32'(frame_done), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
